// File: rtl/sbox_lookup_sched.sv
// ---------------------------------------------------------------------------
// sbox_lookup_sched
//
// Time-multiplexes a single shared 6-in/4-out S-box across the eight
// substitutions of a 48-bit post-XOR word. One word is accepted in IDLE,
// then eight LOOKUP cycles each address one S-box. The nibble that comes back
// in a LOOKUP cycle is written into the 32-bit result. The result is held in
// DONE until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   a 48-bit word is offered on data_in
//   data_in    [47:42] feeds S1 ... [5:0] feeds S8
//   in_ready   block accepts a word this cycle (IDLE only)
//   box_sel    shared S-box being addressed (0 = S1 ... 7 = S8)
//   box_addr   6-bit address presented to the selected S-box
//   box_data   combinational S-box result for box_sel/box_addr
//   out_valid  data_out holds a complete result (DONE only)
//   out_ready  consumer takes data_out this cycle
//   data_out   S1 nibble at [31:28] ... S8 nibble at [3:0]
//   busy       high in LOOKUP and DONE
// ---------------------------------------------------------------------------
module sbox_lookup_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [47:0] data_in,
    output logic        in_ready,
    output logic [2:0]  box_sel,
    output logic [5:0]  box_addr,
    input  logic [3:0]  box_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q,   idx_d;
    logic [47:0] cap_q,   cap_d;
    logic [31:0] dout_q,  dout_d;

    // Handshake and status outputs are pure functions of the state register.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_LOOKUP) || (state_q == ST_DONE);
    assign data_out  = dout_q;

    // S-box addressing comes from registers only, so box_data never loops
    // back combinationally into box_sel/box_addr.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        box_sel  = 3'd0;
        box_addr = 6'd0;
        if (state_q == ST_LOOKUP) begin
            box_sel = idx_q;
            for (int i = 0; i < 8; i++) begin
                if (idx_q == 3'(i)) begin
                    box_addr = cap_q[6*(7-i) +: 6];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cap_d   = data_in;
                    idx_d   = 3'd0;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                for (int i = 0; i < 8; i++) begin
                    if (idx_q == 3'(i)) begin
                        dout_d[4*(7-i) +: 4] = box_data;
                    end
                end
                // The eighth lookup ends the scan; idx parks at 7 instead of
                // wrapping into a ninth lookup.
                if (idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset clears the datapath registers too: a reset mid-lookup
            // must discard the partial result and leave data_out at zero.
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cap_q   <= 48'd0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            dout_q  <= dout_d;
        end
    end

endmodule
